mem_clk_seq: RTL and testbench

//  Power-up/recovery sequencer for the memory-clock PLL (50 MHz in, CLKOUT0 out, LOCK, ENCLK0).

---
 rtl/mem_clk_pkg.sv | 56 +++++
 rtl/mem_clk_lock_sync.sv | 21 ++
 rtl/mem_clk_seq.sv | 148 ++++++++++++++
 tb/tb_mem_clk_seq.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_clk_pkg.sv
// Shared types and defaults for the memory-clock PLL sequencer.
package mem_clk_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned RETRY_W = 2;
  localparam int unsigned LOSS_W  = 8;

  localparam int unsigned DEF_RST_CYCLES    = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT  = 50000;
  localparam int unsigned DEF_STABLE_CYCLES = 1024;
  localparam int unsigned DEF_SETTLE_CYCLES = 64;
  localparam int unsigned DEF_MAX_RETRY     = 3;
  localparam int unsigned DEF_CNT_W         = 16;

  typedef enum logic [STATE_W-1:0] {
    RST_PLL     = 3'd0,
    WAIT_LOCK   = 3'd1,
    LOCK_STABLE = 3'd2,
    SETTLE      = 3'd3,
    RUN         = 3'd4,
    FAULT       = 3'd5
  } state_e;

  typedef struct packed {
    logic pll_reset;
    logic enclk0;
    logic mem_rst_n;
    logic clk_ready;
    logic fault;
  } seq_out_t;

  localparam seq_out_t SEQ_OUT_RST = '{pll_reset: 1'b1, enclk0: 1'b0, mem_rst_n: 1'b0,
                                       clk_ready: 1'b0, fault: 1'b0};

  // Output levels that hold while the sequencer sits in a given state.
  function automatic seq_out_t state_outputs(state_e s);
    seq_out_t o;
    o = '0;
    case (s)
      RST_PLL:  o.pll_reset = 1'b1;
      SETTLE:   o.enclk0    = 1'b1;
      RUN: begin
        o.enclk0    = 1'b1;
        o.mem_rst_n = 1'b1;
        o.clk_ready = 1'b1;
      end
      FAULT: begin
        o.pll_reset = 1'b1;
        o.fault     = 1'b1;
      end
      default:  o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/mem_clk_lock_sync.sv
// Two-flop synchronizer bringing PLL LOCK into the reference clock domain.
module mem_clk_lock_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= 1'b0;
      sync_o <= 1'b0;
    end else begin
      meta   <= async_i;
      sync_o <= meta;
    end
  end

endmodule

// File: rtl/mem_clk_seq.sv
// Memory-clock PLL power-up/recovery sequencer running on the 50 MHz reference.
// Optional lock-loss counter output loss_cnt_o enabled by MEM_CLK_SEQ_LOSS_CNT_EN.
module mem_clk_seq
  import mem_clk_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned MAX_RETRY     = DEF_MAX_RETRY,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pll_lock_i,
  input  logic               restart_i,
  output logic               pll_reset_o,
  output logic               pll_enclk0_o,
  output logic               mem_rst_n_o,
  output logic               clk_ready_o,
  output logic               fault_o,
  output logic [STATE_W-1:0] state_o,
  output logic [RETRY_W-1:0] retry_cnt_o
`ifdef MEM_CLK_SEQ_LOSS_CNT_EN
  ,
  output logic [LOSS_W-1:0]  loss_cnt_o
`endif
);

  localparam logic [63:0] CNT_LIMIT = 64'd1 << CNT_W;

  if (RST_CYCLES == 0 || STABLE_CYCLES == 0 || SETTLE_CYCLES == 0 || LOCK_TIMEOUT == 0 ||
      64'(RST_CYCLES) >= CNT_LIMIT || 64'(LOCK_TIMEOUT) >= CNT_LIMIT ||
      64'(STABLE_CYCLES) >= CNT_LIMIT || 64'(SETTLE_CYCLES) >= CNT_LIMIT ||
      MAX_RETRY >= (32'd1 << RETRY_W)) begin : g_bad_param
    $error("mem_clk_seq: cycle parameter out of range for CNT_W or retry counter");
  end

  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST   = RETRY_W'(MAX_RETRY);

  logic               lock_s;
  state_e             state, state_nxt;
  logic [CNT_W-1:0]   timer, timer_nxt;
  logic [RETRY_W-1:0] retry, retry_nxt;
  seq_out_t           outs, outs_nxt;

  mem_clk_lock_sync u_lock_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (pll_lock_i),
    .sync_o  (lock_s)
  );

  // State, timer, retry count and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RST_PLL;
      timer <= '0;
      retry <= '0;
      outs  <= SEQ_OUT_RST;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      retry <= retry_nxt;
      outs  <= outs_nxt;
    end
  end

  // Next-state logic; restart overrides every other transition.
  always_comb begin
    state_nxt = state;
    retry_nxt = retry;
    if (restart_i) begin
      state_nxt = RST_PLL;
      retry_nxt = '0;
    end else begin
      case (state)
        RST_PLL: begin
          if (timer == RST_LAST) state_nxt = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_nxt = LOCK_STABLE;
          end else if (timer == TIMEOUT_LAST) begin
            if (retry == RETRY_LAST) begin
              state_nxt = FAULT;
            end else begin
              state_nxt = RST_PLL;
              retry_nxt = retry + RETRY_W'(1);
            end
          end
        end
        LOCK_STABLE: begin
          if (!lock_s)                   state_nxt = WAIT_LOCK;
          else if (timer == STABLE_LAST) state_nxt = SETTLE;
        end
        SETTLE: begin
          if (!lock_s) begin
            state_nxt = RST_PLL;
          end else if (timer == SETTLE_LAST) begin
            state_nxt = RUN;
            retry_nxt = '0;
          end
        end
        RUN: begin
          if (!lock_s) state_nxt = RST_PLL;
        end
        FAULT:   state_nxt = FAULT;
        default: state_nxt = RST_PLL;
      endcase
    end

    // Timer restarts on every state entry and saturates instead of wrapping.
    if (restart_i || (state_nxt != state)) timer_nxt = '0;
    else if (~&timer)                       timer_nxt = timer + CNT_W'(1);
    else                                    timer_nxt = timer;

    outs_nxt = state_outputs(state_nxt);
  end

  assign pll_reset_o  = outs.pll_reset;
  assign pll_enclk0_o = outs.enclk0;
  assign mem_rst_n_o  = outs.mem_rst_n;
  assign clk_ready_o  = outs.clk_ready;
  assign fault_o      = outs.fault;
  assign state_o      = state;
  assign retry_cnt_o  = retry;

`ifdef MEM_CLK_SEQ_LOSS_CNT_EN
  logic [LOSS_W-1:0] loss_cnt;

  // Counts lock losses out of RUN; survives restart, cleared only by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loss_cnt <= '0;
    end else if (!restart_i && (state == RUN) && !lock_s && (~&loss_cnt)) begin
      loss_cnt <= loss_cnt + LOSS_W'(1);
    end
  end

  assign loss_cnt_o = loss_cnt;
`endif

endmodule

// File: tb/tb_mem_clk_seq.sv
// Self-checking bench for mem_clk_seq: directed vector table, corner sequences,
// and randomized lock/restart traffic against a timestamp-based reference model.
module tb_mem_clk_seq;

  localparam int P_RST       = 4;
  localparam int P_TIMEOUT   = 100;
  localparam int P_STABLE    = 8;
  localparam int P_SETTLE    = 4;
  localparam int P_MAX_RETRY = 2;

  localparam int S_RST = 0, S_WAIT = 1, S_STAB = 2, S_SETTLE = 3, S_RUN = 4, S_FAULT = 5;

  logic       clk;
  logic       rst_n;
  logic       pll_lock_i;
  logic       restart_i;
  logic       pll_reset_o;
  logic       pll_enclk0_o;
  logic       mem_rst_n_o;
  logic       clk_ready_o;
  logic       fault_o;
  logic [2:0] state_o;
  logic [1:0] retry_cnt_o;
`ifdef MEM_CLK_SEQ_LOSS_CNT_EN
  logic [7:0] loss_cnt_o;
`endif

  int checks   = 0;
  int failures = 0;

  mem_clk_seq #(
    .RST_CYCLES    (P_RST),
    .LOCK_TIMEOUT  (P_TIMEOUT),
    .STABLE_CYCLES (P_STABLE),
    .SETTLE_CYCLES (P_SETTLE),
    .MAX_RETRY     (P_MAX_RETRY),
    .CNT_W         (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pll_lock_i   (pll_lock_i),
    .restart_i    (restart_i),
    .pll_reset_o  (pll_reset_o),
    .pll_enclk0_o (pll_enclk0_o),
    .mem_rst_n_o  (mem_rst_n_o),
    .clk_ready_o  (clk_ready_o),
    .fault_o      (fault_o),
    .state_o      (state_o),
    .retry_cnt_o  (retry_cnt_o)
`ifdef MEM_CLK_SEQ_LOSS_CNT_EN
    ,
    .loss_cnt_o   (loss_cnt_o)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Expected output vector: {state, pll_reset, enclk0, mem_rst_n, clk_ready, fault, retry}.
  function automatic logic [9:0] mk(int st, bit pr, bit en, bit mr, bit rdy, bit f, int rt);
    return {3'(st), pr, en, mr, rdy, f, 2'(rt)};
  endfunction

  function automatic logic [9:0] dut_vec();
    return {state_o, pll_reset_o, pll_enclk0_o, mem_rst_n_o, clk_ready_o, fault_o, retry_cnt_o};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: tracks the edge on which each state was entered and the lock
  // value seen two edges ago; transitions follow the sequencing rules directly.
  int m_st, m_retry, m_cyc, m_entry, m_loss;
  bit lq[$];

  task automatic model_reset();
    m_st = S_RST; m_retry = 0; m_cyc = 0; m_entry = 0; m_loss = 0;
    lq = '{1'b0, 1'b0};
  endtask

  task automatic model_edge();
    bit ls;
    int spent;
    int ns;
    m_cyc++;
    ls = lq.pop_front();
    lq.push_back(pll_lock_i);
    spent = m_cyc - m_entry;
    ns = m_st;
    if (restart_i) begin
      ns = S_RST;
      m_retry = 0;
      m_entry = m_cyc;
    end else begin
      case (m_st)
        S_RST:    if (spent == P_RST) ns = S_WAIT;
        S_WAIT:   if (ls) ns = S_STAB;
                  else if (spent == P_TIMEOUT) begin
                    if (m_retry == P_MAX_RETRY) ns = S_FAULT;
                    else begin m_retry++; ns = S_RST; end
                  end
        S_STAB:   if (!ls) ns = S_WAIT; else if (spent == P_STABLE) ns = S_SETTLE;
        S_SETTLE: if (!ls) ns = S_RST;
                  else if (spent == P_SETTLE) begin ns = S_RUN; m_retry = 0; end
        S_RUN:    if (!ls) begin ns = S_RST; if (m_loss < 255) m_loss++; end
        default:  ;
      endcase
      if (ns != m_st) m_entry = m_cyc;
    end
    m_st = ns;
  endtask

  function automatic logic [9:0] model_vec();
    return mk(m_st, (m_st == S_RST) || (m_st == S_FAULT), (m_st == S_SETTLE) || (m_st == S_RUN),
              m_st == S_RUN, m_st == S_RUN, m_st == S_FAULT, m_retry);
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; pll_lock_i = 1'b0; restart_i = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit         lock;
    bit         restart;
    int         n;
    logic [9:0] exp;
    int         loss;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit lk, bit rs, int n, int st, bit pr, bit en, bit mr, bit rdy,
                              bit f, int rt, int loss);
    vec_t v;
    v.lock = lk; v.restart = rs; v.n = n; v.exp = mk(st, pr, en, mr, rdy, f, rt); v.loss = loss;
    tbl.push_back(v);
  endfunction

  initial begin
    int pulses, bad, hold;
    bit prev;
    logic [2:0] seen;

    // Edge-by-edge walk: bring-up, lock loss in RUN, glitch in LOCK_STABLE, restart in SETTLE.
    add(0, 0, 3, S_RST,    1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, S_WAIT,   0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 6, S_WAIT,   0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 2, S_WAIT,   0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 1, S_STAB,   0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 7, S_STAB,   0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 1, S_SETTLE, 0, 1, 0, 0, 0, 0, 0);
    add(1, 0, 3, S_SETTLE, 0, 1, 0, 0, 0, 0, 0);
    add(1, 0, 1, S_RUN,    0, 1, 1, 1, 0, 0, 0);
    add(0, 0, 2, S_RUN,    0, 1, 1, 1, 0, 0, 0);
    add(0, 0, 1, S_RST,    1, 0, 0, 0, 0, 0, 1);
    add(1, 0, 4, S_WAIT,   0, 0, 0, 0, 0, 0, 1);
    add(1, 0, 1, S_STAB,   0, 0, 0, 0, 0, 0, 1);
    add(1, 0, 4, S_STAB,   0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 1, S_STAB,   0, 0, 0, 0, 0, 0, 1);
    add(1, 0, 1, S_STAB,   0, 0, 0, 0, 0, 0, 1);
    add(1, 0, 1, S_WAIT,   0, 0, 0, 0, 0, 0, 1);
    add(1, 0, 1, S_STAB,   0, 0, 0, 0, 0, 0, 1);
    add(1, 0, 7, S_STAB,   0, 0, 0, 0, 0, 0, 1);
    add(1, 0, 1, S_SETTLE, 0, 1, 0, 0, 0, 0, 1);
    add(1, 0, 2, S_SETTLE, 0, 1, 0, 0, 0, 0, 1);
    add(1, 1, 1, S_RST,    1, 0, 0, 0, 0, 0, 1);
    add(1, 0, 3, S_RST,    1, 0, 0, 0, 0, 0, 1);
    add(1, 0, 1, S_WAIT,   0, 0, 0, 0, 0, 0, 1);
    add(1, 0, 1, S_STAB,   0, 0, 0, 0, 0, 0, 1);

    do_reset();
    check("reset_vec", 32'(dut_vec()), 32'(mk(S_RST, 1, 0, 0, 0, 0, 0)));
    foreach (tbl[i]) begin
      pll_lock_i = tbl[i].lock;
      restart_i  = tbl[i].restart;
      repeat (tbl[i].n) tick();
      check($sformatf("vec%0d", i), 32'(dut_vec()), 32'(tbl[i].exp));
`ifdef MEM_CLK_SEQ_LOSS_CNT_EN
      check($sformatf("vec%0d_loss", i), 32'(loss_cnt_o), 32'(tbl[i].loss));
`endif
    end
    restart_i = 1'b0;

    // Lock never arrives: three reset pulses, then FAULT on the third timeout.
    do_reset();
    pulses = 1; seen = 3'b001; prev = 1'b1;
    repeat (311) begin
      tick();
      if (pll_reset_o && !prev) begin
        pulses++;
        seen[retry_cnt_o] = 1'b1;
      end
      prev = pll_reset_o;
    end
    check("reset_pulses", 32'(pulses), 32'd3);
    check("retry_values", 32'(seen), 32'd7);
    check("pre_fault", 32'(dut_vec()), 32'(mk(S_WAIT, 0, 0, 0, 0, 0, 2)));
    tick();
    check("fault_entry", 32'(dut_vec()), 32'(mk(S_FAULT, 1, 0, 0, 0, 1, 2)));
    bad = 0;
    repeat (1000) begin
      pll_lock_i = 1'($urandom_range(0, 1));
      tick();
      if (dut_vec() !== mk(S_FAULT, 1, 0, 0, 0, 1, 2)) bad++;
    end
    check("fault_hold", 32'(bad), 32'd0);
    pll_lock_i = 1'b0;
    restart_i  = 1'b1;
    tick();
    restart_i  = 1'b0;
    check("restart_from_fault", 32'(dut_vec()), 32'(mk(S_RST, 1, 0, 0, 0, 0, 0)));

    // Reach RUN, then assert rst_n between clock edges.
    pll_lock_i = 1'b1;
    repeat (30) tick();
    check("run_reached", 32'(dut_vec()), 32'(mk(S_RUN, 0, 1, 1, 1, 0, 0)));
    #2 rst_n = 1'b0;
    #1 check("async_reset", 32'(dut_vec()), 32'(mk(S_RST, 1, 0, 0, 0, 0, 0)));
`ifdef MEM_CLK_SEQ_LOSS_CNT_EN
    check("async_reset_loss", 32'(loss_cnt_o), 32'd0);
`endif
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_reset_rst", 32'(dut_vec()), 32'(mk(S_RST, 1, 0, 0, 0, 0, 0)));
    repeat (3) tick();
    check("post_reset_wait", 32'(dut_vec()), 32'(mk(S_WAIT, 0, 0, 0, 0, 0, 0)));
    tick();
    check("post_reset_stab", 32'(dut_vec()), 32'(mk(S_STAB, 0, 0, 0, 0, 0, 0)));

    // Randomized lock activity and occasional restarts checked against the model.
    do_reset();
    hold = 0;
    repeat (5000) begin
      if (hold == 0) begin
        int r;
        r = int'($urandom_range(0, 9));
        pll_lock_i = 1'($urandom_range(0, 1));
        if (r < 4)      hold = int'($urandom_range(1, 3));
        else if (r < 8) hold = int'($urandom_range(5, 20));
        else            hold = int'($urandom_range(90, 160));
      end
      hold--;
      restart_i = ($urandom_range(0, 149) == 0);
      tick();
      check("random", 32'(dut_vec()), 32'(model_vec()));
`ifdef MEM_CLK_SEQ_LOSS_CNT_EN
      check("random_loss", 32'(loss_cnt_o), 32'(m_loss));
`endif
    end
    restart_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
